// File: rtl/bitrev_pkg.sv
// Shared types and helpers for the bit-reversal receive path.
// Provides word width, counter width, holding-state enum, reverse/palindrome.
package bitrev_pkg;

    localparam int WORD_W = 8;
    localparam int CNT_W  = $clog2(WORD_W);

    typedef enum logic {
        HOLD_EMPTY,
        HOLD_FULL
    } hold_e;

    function automatic logic [WORD_W-1:0] reverse(
        input logic [WORD_W-1:0] w
    );
        logic [WORD_W-1:0] r;
        for (int i = 0; i < WORD_W; i++) begin
            r[WORD_W-1-i] = w[i];
        end
        return r;
    endfunction

    function automatic logic palindrome(
        input logic [WORD_W-1:0] w
    );
        return w == reverse(w);
    endfunction

endpackage

// File: rtl/bitrev_deser_bitrev.sv
// Combinational bit reversal and palindrome detect for an N-bit word.
// Ports: word (in, N), rev (out, N), palind (out, 1).
module bitrev_deser_bitrev #(
    parameter int N = 8
) (
    input  logic [N-1:0] word,
    output logic [N-1:0] rev,
    output logic         palind
);

    always_comb begin
        rev = '0;
        for (int i = 0; i < N; i++) begin
            rev[N-1-i] = word[i];
        end
    end

    assign palind = (word == rev);

endmodule

// File: rtl/bitrev_deser.sv
// Serial-to-parallel receiver: LSB-first bits into N-bit words, with reversed
// copy and palindrome flag behind a one-entry valid/ready holding register.
// Ports: clk, rst (sync high); bit_in/bit_valid/frame_start/bit_ready (serial
// side); out_word/out_rev/out_palind/out_valid/out_ready (parallel side);
// frame_err (pulse when a partial word is dropped by frame_start).
module bitrev_deser
    import bitrev_pkg::*;
#(
    parameter int N = WORD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bit_in,
    input  logic         bit_valid,
    input  logic         frame_start,
    output logic         bit_ready,
    output logic [N-1:0] out_word,
    output logic [N-1:0] out_rev,
    output logic         out_palind,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         frame_err
);

    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    hold_e         state_q;
    hold_e         state_d;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  shift_q;
    logic [N-1:0]  shift_d;
    logic [N-1:0]  word_rev;
    logic          word_pal;
    logic          last;
    logic          accept;
    logic          start;
    logic          complete;

    assign last      = (cnt_q == LAST);
    assign out_valid = (state_q == HOLD_FULL);

    // Only a completing bit can be stalled; a frame_start bit restarts the
    // word instead of completing it, so it always goes through.
    assign bit_ready = !(last && out_valid && !out_ready
                         && !(bit_valid && frame_start));

    assign accept   = bit_valid && bit_ready;
    assign start    = accept && frame_start;
    assign complete = accept && !frame_start && last;

    // Next shift contents include the bit arriving now, so a completed word
    // is available to the holding register on the same edge.
    always_comb begin
        shift_d = shift_q;
        if (start) begin
            shift_d    = '0;
            shift_d[0] = bit_in;
        end else if (accept) begin
            shift_d[cnt_q] = bit_in;
        end
    end

    bitrev_deser_bitrev #(
        .N(N)
    ) u_bitrev (
        .word  (shift_d),
        .rev   (word_rev),
        .palind(word_pal)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HOLD_EMPTY: if (complete) state_d = HOLD_FULL;
            HOLD_FULL:  if (!complete && out_ready) state_d = HOLD_EMPTY;
            default:    state_d = HOLD_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HOLD_EMPTY;
            cnt_q      <= '0;
            shift_q    <= '0;
            out_word   <= '0;
            out_rev    <= '0;
            out_palind <= 1'b1;
            frame_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            frame_err <= start && (cnt_q != '0);
            if (start) begin
                cnt_q <= CW'(1);
            end else if (accept) begin
                cnt_q <= last ? '0 : cnt_q + 1'b1;
            end
            if (complete) begin
                out_word   <= shift_d;
                out_rev    <= word_rev;
                out_palind <= word_pal;
            end
        end
    end

endmodule

// File: tb/tb_bitrev_deser.sv
// Self-checking bench for bitrev_deser (N=8): directed vectors plus a
// random-stream scoreboard run.
module tb_bitrev_deser;
    import bitrev_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic       bit_ready;
    logic [7:0] out_word;
    logic [7:0] out_rev;
    logic       out_palind;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       frame_err;

    int n_cmp = 0;
    int n_err = 0;
    int err_cnt = 0;

    bit         rnd_on = 1'b0;
    logic [7:0] m_word = '0;
    int         m_cnt = 0;
    int         acc_bits = 0;
    int         got_words = 0;
    logic [7:0] exp_q[$];

    bitrev_deser #(.N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .frame_start(frame_start),
        .bit_ready  (bit_ready),
        .out_word   (out_word),
        .out_rev    (out_rev),
        .out_palind (out_palind),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic fs);
        int t;
        @(negedge clk);
        bit_valid   = 1'b1;
        bit_in      = b;
        frame_start = fs;
        t = 0;
        #1;
        while (!bit_ready && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t == 100) check("bit_ready_timeout", 32'(bit_ready), 32'd1);
        @(posedge clk);
        #1;
        bit_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(w[i], 1'b0);
    endtask

    task automatic check_out(input string tag, input logic [7:0] w,
                             input logic [7:0] r, input logic p);
        check({tag, "_word"}, 32'(out_word), 32'(w));
        check({tag, "_rev"}, 32'(out_rev), 32'(r));
        check({tag, "_pal"}, 32'(out_palind), 32'(p));
    endtask

    always @(negedge clk) if (frame_err) err_cnt++;

    // Scoreboard: inputs are stable at the falling edge, so handshakes seen
    // here are exactly those that complete at the next rising edge.
    always @(negedge clk) begin
        if (rnd_on) begin
            if (bit_valid && bit_ready) begin
                m_word[m_cnt] = bit_in;
                m_cnt++;
                acc_bits++;
                if (m_cnt == 8) begin
                    exp_q.push_back(m_word);
                    m_cnt = 0;
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_underflow", 32'(out_valid), 32'd0);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("rnd_word", 32'(out_word), 32'(e));
                    check("rnd_rev", 32'(out_rev), 32'(reverse(e)));
                    check("rnd_pal", 32'(out_palind), 32'(palindrome(e)));
                    got_words++;
                end
            end
        end
    end

    initial begin
        int it;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check_out("rst", 8'h00, 8'h00, 1'b1);
        check("rst_ferr", 32'(frame_err), 32'd0);
        check("rst_ready", 32'(bit_ready), 32'd1);

        // 1,0,1,1,0,0,0,0 -> 0x0D
        out_ready = 1'b1;
        send_word(8'h0D);
        @(negedge clk);
        check("w0d_valid", 32'(out_valid), 32'd1);
        check_out("w0d", 8'h0D, 8'hB0, 1'b0);
        @(negedge clk);
        check("w0d_drop", 32'(out_valid), 32'd0);
        check("w0d_hold", 32'(out_word), 32'h0D);

        send_word(8'h81);
        @(negedge clk);
        check("w81_valid", 32'(out_valid), 32'd1);
        check_out("w81", 8'h81, 8'h81, 1'b1);

        // Back-pressure: 0x0F held, 0xF0's last bit stalls.
        @(negedge clk);
        out_ready = 1'b0;
        send_word(8'h0F);
        @(negedge clk);
        check("w0f_valid", 32'(out_valid), 32'd1);
        check("w0f_word", 32'(out_word), 32'h0F);
        for (int i = 0; i < 7; i++) begin
            logic [7:0] f0;
            f0 = 8'hF0;
            send_bit(f0[i], 1'b0);
        end
        @(negedge clk);
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        #1;
        check("bp_stall", 32'(bit_ready), 32'd0);
        @(negedge clk);
        check("bp_stall2", 32'(bit_ready), 32'd0);
        check("bp_held", 32'(out_word), 32'h0F);
        check("bp_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp_release", 32'(bit_ready), 32'd1);
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        out_ready = 1'b0;
        check("bp_nobubble", 32'(out_valid), 32'd1);
        check("bp_f0", 32'(out_word), 32'hF0);
        check("bp_f0_rev", 32'(out_rev), 32'h0F);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_drain", 32'(out_valid), 32'd0);

        // Partial word dropped by frame_start, then 0xA5.
        err_cnt = 0;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b1);
        check("fe_pulse", 32'(frame_err), 32'd1);
        for (int i = 1; i < 8; i++) begin
            logic [7:0] a5;
            a5 = 8'hA5;
            send_bit(a5[i], 1'b0);
        end
        @(negedge clk);
        check("fe_count", 32'(err_cnt), 32'd1);
        check("fe_valid", 32'(out_valid), 32'd1);
        check_out("fe", 8'hA5, 8'hA5, 1'b1);

        // Reset mid-word.
        @(negedge clk);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rmid_valid", 32'(out_valid), 32'd0);
        check_out("rmid", 8'h00, 8'h00, 1'b1);

        // Reset with a word held.
        out_ready = 1'b0;
        send_word(8'h3C);
        @(negedge clk);
        check("rhold_pre", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rhold_valid", 32'(out_valid), 32'd0);
        check_out("rhold", 8'h00, 8'h00, 1'b1);
        out_ready = 1'b1;
        send_word(8'h12);
        @(negedge clk);
        check("clean_valid", 32'(out_valid), 32'd1);
        check_out("clean", 8'h12, 8'h48, 1'b0);
        @(negedge clk);
        check("clean_drain", 32'(out_valid), 32'd0);

        // Random stream with random back-pressure.
        rnd_on = 1'b1;
        it = 0;
        while (acc_bits < 8000 && it < 40000) begin
            @(posedge clk);
            #1;
            if (acc_bits >= 8000) begin
                bit_valid = 1'b0;
            end else begin
                bit_valid = ($urandom_range(0, 3) != 0);
                bit_in    = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            it++;
        end
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rnd_on = 1'b0;
        check("rnd_bits", 32'(acc_bits), 32'd8000);
        check("rnd_words", 32'(got_words), 32'd1000);
        check("rnd_left", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
